// File: rtl/spi_cmd_slave.sv
// Oversampled SPI target: synchronizes SCK/SDI/CS, decodes {command, data word} frames and shifts read data out on SDO.
// Abort counter on err_count is built only when SPI_CMD_SLAVE_ERRCNT_EN is defined.
module spi_cmd_slave #(
    parameter int CMD_WIDTH   = 8,
    parameter int WORD_WIDTH  = 32,
    parameter int SPI_MODE    = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sck_async,
    input  logic                  sdi_async,
    input  logic                  cs_async,
    output logic                  sdo,
    output logic [CMD_WIDTH-1:0]  cmd,
    output logic [WORD_WIDTH-1:0] wdata,
    output logic                  cmd_valid,
    output logic                  rd_req,
    input  logic [WORD_WIDTH-1:0] rdata,
    output logic                  busy,
    output logic [7:0]            err_count,
    output logic [1:0]            dbg_state
);

    localparam logic CPOL        = 1'((SPI_MODE >> 1) & 1);
    localparam logic CPHA        = 1'(SPI_MODE & 1);
    localparam bit   SAMPLE_RISE = (CPOL == CPHA);
    localparam int   TOTAL       = CMD_WIDTH + WORD_WIDTH;
    localparam int   CNT_W       = $clog2(TOTAL + 1);
    localparam int   SH_W        = (CMD_WIDTH > WORD_WIDTH) ? CMD_WIDTH : WORD_WIDTH;
    localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(CMD_WIDTH - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(TOTAL);

    // Handshake: cmd_valid and rd_req are single-cycle strobes with no back-pressure;
    // rdata must be stable on the cycle after rd_req, when it is captured.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMD  = 2'd1,
        S_DATA = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_sdi_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic                   r_sck_d;
    logic [SYNC_STAGES:0]   r_settle;
    logic                   r_armed;

    logic w_sck;
    logic w_sdi;
    logic w_cs;
    logic w_sck_rise;
    logic w_sck_fall;
    logic w_sample;
    logic w_shift;

    logic [CNT_W-1:0]      r_bit_cnt;
    logic [SH_W-2:0]       r_in_shift;
    logic [SH_W-1:0]       w_in_next;
    logic [CMD_WIDTH-1:0]  r_cmd_lat;
    logic                  r_is_read;
    logic [CMD_WIDTH-1:0]  r_cmd;
    logic [WORD_WIDTH-1:0] r_wdata;
    logic                  r_cmd_valid;
    logic                  r_rd_req;
    logic                  r_load;
    logic [WORD_WIDTH-1:0] r_out_shift;
    logic                  r_sdo_bit;

    logic w_cmd_done;
    logic w_data_done;

    // Input synchronizers; SCK resets to its idle level so no edge is seen at reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sck_sync <= {SYNC_STAGES{CPOL}};
            r_sdi_sync <= '0;
            r_cs_sync  <= '1;
            r_sck_d    <= CPOL;
        end else begin
            r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], sck_async};
            r_sdi_sync <= {r_sdi_sync[SYNC_STAGES-2:0], sdi_async};
            r_cs_sync  <= {r_cs_sync[SYNC_STAGES-2:0], cs_async};
            r_sck_d    <= r_sck_sync[SYNC_STAGES-1];
        end
    end

    assign w_sck      = r_sck_sync[SYNC_STAGES-1];
    assign w_sdi      = r_sdi_sync[SYNC_STAGES-1];
    assign w_cs       = r_cs_sync[SYNC_STAGES-1];
    assign w_sck_rise = w_sck & ~r_sck_d;
    assign w_sck_fall = ~w_sck & r_sck_d;
    assign w_sample   = SAMPLE_RISE ? w_sck_rise : w_sck_fall;
    assign w_shift    = SAMPLE_RISE ? w_sck_fall : w_sck_rise;

    // A frame may start only after CS has been seen high on real (post-reset) samples,
    // so a frame already running when reset releases is ignored until CS cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_settle <= '0;
            r_armed  <= 1'b0;
        end else begin
            r_settle <= {r_settle[SYNC_STAGES-1:0], 1'b1};
            if (r_settle[SYNC_STAGES] && w_cs) begin
                r_armed <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cmd_done  = 1'b0;
        w_data_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_armed && !w_cs) begin
                    w_state_nxt = S_CMD;
                end
            end
            S_CMD: begin
                if (w_cs) begin
                    w_state_nxt = S_IDLE;
                end else if (w_sample && r_bit_cnt == CMD_LAST) begin
                    w_cmd_done  = 1'b1;
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                // A final sample edge seen together with CS high still completes the frame.
                if (w_sample && r_bit_cnt == DATA_LAST) begin
                    w_data_done = 1'b1;
                    w_state_nxt = w_cs ? S_IDLE : S_DONE;
                end else if (w_cs) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_DONE: begin
                if (w_cs) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_in_next = {r_in_shift, w_sdi};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt  <= '0;
            r_in_shift <= '0;
        end else begin
            if (w_cs || r_state == S_IDLE) begin
                r_bit_cnt <= '0;
            end else if (w_sample && r_bit_cnt != CNT_MAX) begin
                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end
            if (w_sample && (r_state == S_CMD || r_state == S_DATA)) begin
                r_in_shift <= w_in_next[SH_W-2:0];
            end
        end
    end

    // The command is held privately until the frame completes so an abort leaves cmd untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd_lat   <= '0;
            r_is_read   <= 1'b0;
            r_rd_req    <= 1'b0;
            r_cmd_valid <= 1'b0;
            r_cmd       <= '0;
            r_wdata     <= '0;
        end else begin
            r_rd_req    <= 1'b0;
            r_cmd_valid <= w_data_done;
            if (w_cmd_done) begin
                r_cmd_lat <= w_in_next[CMD_WIDTH-1:0];
                r_is_read <= w_in_next[CMD_WIDTH-1];
                r_rd_req  <= w_in_next[CMD_WIDTH-1];
            end
            if (w_data_done) begin
                r_cmd   <= r_cmd_lat;
                r_wdata <= w_in_next[WORD_WIDTH-1:0];
            end
        end
    end

    // rdata is captured one cycle after rd_req; the first shift edge then presents its MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_load      <= 1'b0;
            r_out_shift <= '0;
            r_sdo_bit   <= 1'b0;
        end else begin
            r_load <= r_rd_req;
            if (r_load) begin
                r_out_shift <= rdata;
            end else if (w_shift && r_state == S_DATA && r_is_read) begin
                r_sdo_bit   <= r_out_shift[WORD_WIDTH-1];
                r_out_shift <= {r_out_shift[WORD_WIDTH-2:0], 1'b0};
            end
            if (r_state != S_DATA) begin
                r_sdo_bit <= 1'b0;
            end
        end
    end

`ifdef SPI_CMD_SLAVE_ERRCNT_EN
    logic       w_abort;
    logic [7:0] r_err_count;

    assign w_abort = (r_state == S_CMD || r_state == S_DATA) && w_cs && !w_data_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_count <= 8'd0;
        end else if (w_abort && r_err_count != 8'hFF) begin
            r_err_count <= r_err_count + 8'd1;
        end
    end

    assign err_count = r_err_count;
`else
    assign err_count = 8'd0;
`endif

    assign sdo       = r_sdo_bit & r_is_read & (r_state == S_DATA);
    assign cmd       = r_cmd;
    assign wdata     = r_wdata;
    assign cmd_valid = r_cmd_valid;
    assign rd_req    = r_rd_req;
    assign busy      = (r_state == S_CMD) || (r_state == S_DATA);
    assign dbg_state = r_state;

endmodule

// File: doc/spi_cmd_slave.md
# spi_cmd_slave

Parametrised, oversampled SPI target for the Raspberry Pi–driven test designs. It brings SCK/SDI/CS into the fabric clock domain, decodes a frame made of a command field and a data word, and presents write frames to the fabric as a one-cycle strobe. It also shifts a fabric-supplied word back out on SDO for read commands. It replaces the ad-hoc synchronizer, edge-detect and bit-counter logic in each test top.

## Interface
Parameters:
- CMD_WIDTH, default 8: command field width in bits; the command MSB set to 1 means read.
- WORD_WIDTH, default 32: data word width in bits.
- SPI_MODE, default 0: SPI mode 0–3; CPOL = bit 1, CPHA = bit 0.
- SYNC_STAGES, default 2: flip-flop stages on each async input; must be ≥ 2.

Ports:
- clk  in  1  fabric clock; all logic is on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- sck_async  in  1  SPI clock from the host, asynchronous.
- sdi_async  in  1  host-to-target data, asynchronous.
- cs_async  in  1  chip select, active low, asynchronous.
- sdo  out  1  target-to-host data.
- cmd  out  CMD_WIDTH  last captured command.
- wdata  out  WORD_WIDTH  last captured data word.
- cmd_valid  out  1  one-cycle strobe: a complete frame was received.
- rd_req  out  1  one-cycle strobe: a read command was decoded.
- rdata  in  WORD_WIDTH  read data; sampled on the cycle after rd_req.
- busy  out  1  high while CS is asserted and the frame is not yet complete.
- err_count  out  8  count of aborted frames (see Configuration).

## Operation
- Synchronizer: SYNC_STAGES flops per input, with reset value sck=CPOL, sdi=0, cs=1. A 1-flop history drives the edge detect.
- Sample edge: rising edge of SCK when CPOL==CPHA, otherwise falling edge. Shift edge is the opposite edge.
- Bit counter width is $clog2(CMD_WIDTH+WORD_WIDTH+1). It clears while CS is high and increments on each sample edge. It saturates at CMD_WIDTH+WORD_WIDTH.
- The input shift register takes data MSB-first.
- State machine:
  - IDLE: CS high. Falling CS → CMD.
  - CMD: after CMD_WIDTH sample edges, latch cmd. If cmd MSB = 1, pulse rd_req and go to DATA; rdata is loaded into the output shift register the next clk.
  - DATA: after WORD_WIDTH further sample edges, latch wdata, pulse cmd_valid, go to DONE.
  - DONE: any further SCK edges are ignored and sdo = 0. Rising CS → IDLE.
  - Rising CS in CMD or DATA is an abort: go to IDLE, no cmd_valid, and cmd/wdata keep their previous values.
- sdo drive:
  - Low in IDLE, CMD and DONE.
  - In DATA for a read, the output register MSB is placed on sdo at the first shift edge after the command completes, then shifts on each shift edge.
  - In DATA for a write, sdo = 0.
- Read frames also pulse cmd_valid at frame end; the wdata captured then is don't-care for the host.
- cmd_valid and rd_req are never high in the same cycle.

## Timing
- Reset values: sdo=0, cmd=0, wdata=0, cmd_valid=0, rd_req=0, busy=0, err_count=0, state IDLE.
- Input-to-detect latency: SYNC_STAGES+1 clk from the pin to the internal edge.
- cmd_valid and rd_req assert on the clk after the detected sample edge that completes the field.
- The host SCK half-period must be ≥ SYNC_STAGES+4 clk, so rdata is loaded before the next shift edge.
- CS rising and the final sample edge detected in the same clk: the frame completes (cmd_valid pulses), then IDLE.
- Reset asserted mid-frame: everything returns to reset values immediately. A frame already in progress when reset releases is ignored until CS goes high.

## Configuration
- SPI_CMD_SLAVE_ERRCNT_EN defined: err_count increments, saturating at 255, on every abort.
- SPI_CMD_SLAVE_ERRCNT_EN undefined: err_count is tied to 0 and no counter logic is built.

## Test plan
- Mode 0, defaults, write frame cmd=0x12, data=0xDEADBEEF → one cmd_valid; cmd=0x12, wdata=0xDEADBEEF; rd_req never asserts; sdo stays 0.
- Mode 0, read cmd=0x81 with rdata=0xA5A5_0F0F held → rd_req pulses once after bit 8; host samples 0xA5A50F0F on SDO; cmd_valid at frame end.
- Modes 1, 2, 3 with the same read and write frames → identical captured values and identical SDO word.
- CS raised after 20 bits (ERRCNT_EN defined) → no cmd_valid; cmd/wdata unchanged; err_count goes 0→1; the next full frame decodes correctly.
- 48 SCK cycles in one CS window → exactly one cmd_valid; extra bits ignored; sdo=0 after bit 40.
- rst_n pulsed low mid-DATA → all outputs return to reset values; busy=0 until CS cycles; the next frame decodes correctly.
